// File: rtl/ecg_sample_averager.sv
// ecg_sample_averager
//
// Moving-average filter for an ECG ADC stream. Each rising edge of the
// divided sample clock (smallClk, a level in the bigClk domain) captures
// one sample into an N-entry circular window, N = 2**WIN_LOG2. A running
// sum of the window is kept. Once N samples have been captured since
// reset, each capture produces one result (running sum / N). The result
// is presented on a valid/ready output one bigClk cycle after the capture.
//
// Ports
//   bigClk    in   system clock, rising-edge active
//   rst_n     in   asynchronous active-low reset
//   smallClk  in   sample clock level; its rising edge is a sample instant
//   adcData   in   DATA_W unsigned ADC sample
//   avgData   out  DATA_W moving average of the last N samples
//   avgValid  out  avgData holds an unconsumed result
//   avgReady  in   downstream accepts avgData when high with avgValid
//   overrun   out  sticky: a result was overwritten before acceptance
//   filled    out  high once N samples have been captured since reset

module ecg_sample_averager #(
  parameter int DATA_W   = 12,
  parameter int WIN_LOG2 = 2
) (
  input  logic              bigClk,
  input  logic              rst_n,
  input  logic              smallClk,
  input  logic [DATA_W-1:0] adcData,
  output logic [DATA_W-1:0] avgData,
  output logic              avgValid,
  input  logic              avgReady,
  output logic              overrun,
  output logic              filled
);

  localparam int                N     = 1 << WIN_LOG2;
  localparam int                SUM_W = DATA_W + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] LAST = WIN_LOG2'(N - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t              state_q, state_d;
  logic                small_clk_d_q, small_clk_d_d;
  logic [DATA_W-1:0]   win_q [N];
  logic [DATA_W-1:0]   win_d [N];
  logic [WIN_LOG2-1:0] ptr_q, ptr_d;
  logic [SUM_W-1:0]    run_sum_q, run_sum_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   avg_data_q, avg_data_d;
  logic                avg_valid_q, avg_valid_d;
  logic                overrun_q, overrun_d;
  logic                sample_tick;
  logic [DATA_W-1:0]   oldest;

  // The delayed copy resets to 1 so that a smallClk already high when
  // reset releases is not mistaken for a fresh rising edge.
  assign small_clk_d_d = smallClk;
  assign sample_tick   = smallClk & ~small_clk_d_q;
  assign oldest        = win_q[ptr_q];

  // State register
  always_ff @(posedge bigClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: FILL ends on the capture that writes the last window slot
  // for the first time, i.e. the N-th capture since reset.
  always_comb begin
    state_d = state_q;
    if (state_q == FILL && sample_tick && ptr_q == LAST) begin
      state_d = RUN;
    end
  end

  // Output decode
  always_comb begin
    filled = (state_q == RUN);
  end

  // Window, pointer and running sum. The slot being overwritten holds the
  // oldest sample (zero while still filling), so the sum never goes
  // negative and never exceeds N * max sample.
  // pend marks that the capture just made should produce a result; the
  // result itself is loaded one edge later from the updated sum.
  always_comb begin
    win_d     = win_q;
    ptr_d     = ptr_q;
    run_sum_d = run_sum_q;
    pend_d    = 1'b0;
    if (sample_tick) begin
      win_d[ptr_q] = adcData;
      ptr_d        = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
      run_sum_d    = run_sum_q + SUM_W'(adcData) - SUM_W'(oldest);
      pend_d       = (state_q == RUN) || (ptr_q == LAST);
    end
  end

  // Result holding register. A handshake clears valid, but a result
  // loading on the same edge wins and keeps valid high. Loading over an
  // unaccepted result raises the sticky overrun flag.
  always_comb begin
    avg_data_d  = avg_data_q;
    avg_valid_d = avg_valid_q;
    overrun_d   = overrun_q;
    if (avg_valid_q && avgReady) begin
      avg_valid_d = 1'b0;
    end
    if (pend_q) begin
      avg_data_d  = run_sum_q[SUM_W-1:WIN_LOG2];
      avg_valid_d = 1'b1;
      if (avg_valid_q && !avgReady) begin
        overrun_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge bigClk or negedge rst_n) begin
    if (!rst_n) begin
      small_clk_d_q <= 1'b1;
      for (int i = 0; i < N; i++) begin
        win_q[i] <= '0;
      end
      ptr_q       <= '0;
      run_sum_q   <= '0;
      pend_q      <= 1'b0;
      avg_data_q  <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      small_clk_d_q <= small_clk_d_d;
      win_q         <= win_d;
      ptr_q         <= ptr_d;
      run_sum_q     <= run_sum_d;
      pend_q        <= pend_d;
      avg_data_q    <= avg_data_d;
      avg_valid_q   <= avg_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign avgData  = avg_data_q;
  assign avgValid = avg_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_ecg_sample_averager.sv
// tb_ecg_sample_averager
//
// Directed bench for ecg_sample_averager (DATA_W=12, WIN_LOG2=2, N=4).
// Inputs change on the falling edge of bigClk and outputs are sampled on
// the falling edge, so nothing races the active rising edge. A sample
// captured on rising edge P1 shows its result after rising edge P2.

module tb_ecg_sample_averager;

  logic        bigClk;
  logic        rst_n;
  logic        smallClk;
  logic [11:0] adcData;
  logic [11:0] avgData;
  logic        avgValid;
  logic        avgReady;
  logic        overrun;
  logic        filled;

  int checkCount;
  int errorCount;
  int pulseCount;

  ecg_sample_averager #(
    .DATA_W   (12),
    .WIN_LOG2 (2)
  ) dut (
    .bigClk   (bigClk),
    .rst_n    (rst_n),
    .smallClk (smallClk),
    .adcData  (adcData),
    .avgData  (avgData),
    .avgValid (avgValid),
    .avgReady (avgReady),
    .overrun  (overrun),
    .filled   (filled)
  );

  // 10 ns system clock
  initial begin
    bigClk = 1'b0;
    forever #5 bigClk = ~bigClk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge bigClk);
  endtask

  // Raise smallClk with a new sample; returns just after the capture edge
  task automatic applyStimulus(input logic [11:0] d);
    @(negedge bigClk);
    adcData  = d;
    smallClk = 1'b1;
    @(negedge bigClk);
  endtask

  // Finish a 3-high / 3-low smallClk period started by applyStimulus
  task automatic lowPhase();
    step(2);
    smallClk = 1'b0;
    step(3);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    smallClk   = 1'b0;
    adcData    = '0;
    avgReady   = 1'b1;

    // Reset state before any clock edge
    #2;
    checkOutput("rst_avgData", avgData, 0);
    checkOutput("rst_avgValid", avgValid, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_filled", filled, 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Fill: 100,200,300,400 -> only the fourth produces 250
    applyStimulus(12'd100); step(1);
    checkOutput("fill1_valid", avgValid, 0);
    checkOutput("fill1_filled", filled, 0);
    lowPhase();
    applyStimulus(12'd200); step(1);
    checkOutput("fill2_valid", avgValid, 0);
    lowPhase();
    applyStimulus(12'd300); step(1);
    checkOutput("fill3_valid", avgValid, 0);
    checkOutput("fill3_filled", filled, 0);
    lowPhase();
    applyStimulus(12'd400);
    checkOutput("fill4_valid_early", avgValid, 0);
    step(1);
    checkOutput("fill4_valid", avgValid, 1);
    checkOutput("fill4_data", avgData, 250);
    checkOutput("fill4_filled", filled, 1);
    step(1);
    checkOutput("fill4_consumed", avgValid, 0);
    lowPhase();

    // RUN: 800 -> (200+300+400+800)/4 = 425, single-cycle pulse
    applyStimulus(12'd800); step(1);
    checkOutput("run5_valid", avgValid, 1);
    checkOutput("run5_data", avgData, 425);
    step(1);
    checkOutput("run5_pulse_end", avgValid, 0);
    lowPhase();

    // Load coinciding with handshake: window 300,400,800,500 -> 500,
    // then 400,800,500,600 -> 575 loads while 500 is being accepted
    avgReady = 1'b0;
    applyStimulus(12'd500); step(1);
    checkOutput("coin_first_data", avgData, 500);
    lowPhase();
    checkOutput("coin_held_valid", avgValid, 1);
    applyStimulus(12'd600);
    avgReady = 1'b1;
    step(1);
    checkOutput("coin_valid", avgValid, 1);
    checkOutput("coin_data", avgData, 575);
    checkOutput("coin_overrun", overrun, 0);
    step(1);
    checkOutput("coin_consumed", avgValid, 0);
    lowPhase();

    // Overrun: 800,500,600,700 -> 650, then 500,600,700,900 -> 675
    avgReady = 1'b0;
    applyStimulus(12'd700); step(1);
    checkOutput("ovr_first_data", avgData, 650);
    lowPhase();
    applyStimulus(12'd900); step(1);
    checkOutput("ovr_valid", avgValid, 1);
    checkOutput("ovr_data", avgData, 675);
    checkOutput("ovr_flag", overrun, 1);
    avgReady = 1'b1;
    step(1);
    checkOutput("ovr_consumed", avgValid, 0);
    lowPhase();
    checkOutput("ovr_sticky", overrun, 1);

    // Full-scale: four 4095 samples -> 4095 with no sum wrap
    for (int i = 0; i < 4; i++) begin
      applyStimulus(12'd4095);
      lowPhase();
    end
    applyStimulus(12'd4095); step(1);
    checkOutput("max_data", avgData, 4095);
    checkOutput("max_valid", avgValid, 1);
    lowPhase();

    // smallClk held high 20 cycles with changing data: exactly one capture
    // of 0 -> (3*4095+0)/4 = 3071
    pulseCount = 0;
    @(negedge bigClk);
    adcData  = 12'd0;
    smallClk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge bigClk);
      adcData = 12'd1234;
      if (avgValid) pulseCount++;
    end
    checkOutput("hold_pulses", pulseCount, 1);
    checkOutput("hold_data", avgData, 3071);
    smallClk = 1'b0;
    step(3);

    // Second RUN result left pending: 4095,4095,0,0 -> 2047
    avgReady = 1'b0;
    applyStimulus(12'd0); step(1);
    checkOutput("pre_rst_data", avgData, 2047);
    checkOutput("pre_rst_valid", avgValid, 1);

    // Asynchronous reset mid-cycle with smallClk high into release
    smallClk = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_avgData", avgData, 0);
    checkOutput("async_avgValid", avgValid, 0);
    checkOutput("async_overrun", overrun, 0);
    checkOutput("async_filled", filled, 0);
    step(2);
    rst_n    = 1'b1;
    avgReady = 1'b1;
    adcData  = 12'd4000;
    step(5);
    smallClk = 1'b0;
    step(3);

    // Refill: 40,80,120 silent, 160 -> 400/4 = 100
    applyStimulus(12'd40); step(1);
    checkOutput("refill1_valid", avgValid, 0);
    lowPhase();
    applyStimulus(12'd80); step(1);
    checkOutput("refill2_valid", avgValid, 0);
    lowPhase();
    applyStimulus(12'd120); step(1);
    checkOutput("refill3_valid", avgValid, 0);
    checkOutput("refill3_filled", filled, 0);
    lowPhase();
    applyStimulus(12'd160); step(1);
    checkOutput("refill4_valid", avgValid, 1);
    checkOutput("refill4_data", avgData, 100);
    checkOutput("refill4_filled", filled, 1);
    lowPhase();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ecg_sample_averager.md
ECG_SAMPLE_AVERAGER -- requirements
Module: ecg_sample_averager

Interface
REQ-001 Parameter DATA_W, default 12: width of ADC sample and averaged output.
REQ-002 Parameter WIN_LOG2, default 2: log2 of averaging window depth (window N = 2**WIN_LOG2 samples).
REQ-003 bigClk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 smallClk  input  1  divided sample clock from the clock divider, a level signal in the bigClk domain; its rising edge marks a sample instant.
REQ-006 adcData  input  DATA_W  unsigned ECG ADC sample, valid whenever sampled.
REQ-007 avgData  output  DATA_W  moving average of the last N samples.
REQ-008 avgValid  output  1  avgData holds an unconsumed result.
REQ-009 avgReady  input  1  downstream accepts avgData when high with avgValid.
REQ-010 overrun  output  1  sticky flag: a result was overwritten before acceptance.
REQ-011 filled  output  1  high once N samples have been captured since reset.

Function
REQ-012 The block shall register smallClk into smallClkD each cycle; sampleTick = smallClk & ~smallClkD.
REQ-013 On a cycle with sampleTick=1 the block shall capture adcData into an N-entry circular window, replacing the oldest entry.
REQ-014 On the same edge, runSum (width DATA_W+WIN_LOG2, no overflow possible) shall update to runSum + adcData - oldestEntry; empty window entries read as 0.
REQ-015 The block shall have states FILL and RUN; FILL leaves to RUN on the capture edge of the N-th sample since reset; RUN has no exit except reset.
REQ-016 filled shall be 1 exactly when state is RUN.
REQ-017 In FILL, captures shall update window and runSum but shall produce no result.
REQ-018 In RUN, and on the FILL->RUN capture, the block shall load avgData = runSum_new >> WIN_LOG2 (truncating) and set avgValid=1 on the edge after the capture edge (latency 1 bigClk cycle from capture).
REQ-019 avgValid and avgData shall stay stable until a cycle with avgValid & avgReady, after which avgValid shall clear on the next edge unless a new result loads on that edge.
REQ-020 If a new result loads while avgValid=1 and avgReady=0, avgData shall be overwritten, avgValid stays 1, and overrun shall set to 1.
REQ-021 If a new result loads in the same cycle as an accepting handshake, avgValid shall stay 1 with the new avgData and overrun shall not set.
REQ-022 overrun shall clear only on reset.
REQ-023 The window write pointer shall wrap from N-1 to 0.
REQ-024 smallClk held high for many cycles shall produce exactly one capture; smallClk high out of reset shall not produce a capture until it goes low and high again.

Reset
REQ-025 While rst_n=0: state=FILL, window entries=0, runSum=0, pointer=0, smallClkD=1, avgData=0, avgValid=0, overrun=0, filled=0, immediately and independent of bigClk.
REQ-026 Reset asserted mid-operation shall discard all samples and any pending result; after release the block shall require N new captures before the next result.

Verification
REQ-027 smallClk toggling every 3 bigClk cycles, adcData=100,200,300,400 on the four ticks, avgReady=1 -> no avgValid for ticks 1-3; one cycle after tick 4 avgValid=1, avgData=250, filled=1.
REQ-028 Continue with adcData=800 on tick 5 -> avgData=(200+300+400+800)/4=425, one-cycle avgValid pulse.
REQ-029 avgReady=0 across two RUN ticks -> avgValid stays 1, avgData shows second result, overrun=1 and remains 1 after avgReady returns.
REQ-030 adcData=4095 for all ticks -> avgData=4095, no wrap in runSum.
REQ-031 smallClk held high 20 cycles -> exactly one capture; rst_n pulsed low after 2 RUN results -> all outputs 0 asynchronously, next avgValid only after 4 further ticks.
REQ-032 Result load coinciding with avgValid&avgReady handshake -> avgValid stays 1 with new value, overrun stays 0.
